// File: rtl/agc_parity_pkg.sv
// Shared types and helpers for the parity alarm sequencer and its XOR tree.
package agc_parity_pkg;

  localparam int unsigned WORD_W     = 15;
  localparam int unsigned ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapt    = 3'd1,
    StReduce  = 3'd2,
    StCompare = 3'd3,
    StAlarm   = 3'd4,
    StWaitjam = 3'd5
  } state_e;

  // Bit that makes word plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [WORD_W-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/parity_alarm_sequencer_if.sv
// Memory-word / alarm bus between the S-register stage and the parity alarm sequencer.
interface parity_alarm_sequencer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 8
);
  import agc_parity_pkg::*;

  logic [WORD_W-1:0] G_DATA;
  logic              G_PAR;
  logic [ADDR_W-1:0] S_ADDR;
  logic              RD_STB;
  logic              GEN_MODE;
  logic              CHK_EN;
  logic              MONPAR;
  logic              GOJAM;
  logic              GP_OUT;
  logic              GP_VLD;
  logic              ERR_PULSE;
  logic              PALE;
  logic [ADDR_W-1:0] PAL_ADDR;
  logic [CNT_W-1:0]  PAL_CNT;
  logic              RESTART_REQ;
  logic              BUSY;
  logic              OVERRUN;

  modport master (
    output G_DATA, G_PAR, S_ADDR, RD_STB, GEN_MODE, CHK_EN, MONPAR, GOJAM,
    input  GP_OUT, GP_VLD, ERR_PULSE, PALE, PAL_ADDR, PAL_CNT, RESTART_REQ, BUSY, OVERRUN
  );

  modport slave (
    input  G_DATA, G_PAR, S_ADDR, RD_STB, GEN_MODE, CHK_EN, MONPAR, GOJAM,
    output GP_OUT, GP_VLD, ERR_PULSE, PALE, PAL_ADDR, PAL_CNT, RESTART_REQ, BUSY, OVERRUN
  );

endinterface

// File: rtl/parity_tree15.sv
// Two-stage registered XOR reduction of a 15-bit word to its odd-parity bit (latency 2).
module parity_tree15
  import agc_parity_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  output logic              par,
  output logic              vld
);

  logic lo_q, hi_q, v1_q;
  logic par_q, v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q  <= 1'b0;
      hi_q  <= 1'b0;
      v1_q  <= 1'b0;
      par_q <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      v1_q <= en;
      v2_q <= v1_q;
      if (en) begin
        lo_q <= ^word[7:0];
        hi_q <= ^word[WORD_W-1:8];
      end
      if (v1_q) begin
        par_q <= ~(lo_q ^ hi_q);
      end
    end
  end

  assign par = par_q;
  assign vld = v2_q;

endmodule

// File: rtl/parity_alarm_sequencer.sv
// Parity check/generate for memory words with the PALE alarm, restart request and GOJAM clear.
module parity_alarm_sequencer
  import agc_parity_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ALARM_HOLD = 4
) (
  input  logic                     SIM_CLK,
  input  logic                     SIM_RST,
  parity_alarm_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = StIdle;
  localparam logic [2:0] S_CAPT    = StCapt;
  localparam logic [2:0] S_REDUCE  = StReduce;
  localparam logic [2:0] S_COMPARE = StCompare;
  localparam logic [2:0] S_ALARM   = StAlarm;
  localparam logic [2:0] S_WAITJAM = StWaitjam;
  localparam logic [3:0] HOLD_LAST = 4'(ALARM_HOLD - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        hold_q, hold_d;
  logic [WORD_W-1:0] g_data_q;
  logic              g_par_q, gen_q, chk_en_q, monpar_q;
  logic [ADDR_W-1:0] s_addr_q, pal_addr_q;
  logic [CNT_W-1:0]  pal_cnt_q;
  logic              pale_q, overrun_q, gp_out_q;
  logic              tree_par, tree_vld;
  logic              accept, cmp_go, gen_fire, fail, hold_last;

  assign accept    = (state_q == S_IDLE) && bus.RD_STB && !bus.GOJAM;
  assign cmp_go    = (state_q == S_COMPARE) && tree_vld && !bus.GOJAM;
  assign gen_fire  = cmp_go && gen_q;
  assign fail      = cmp_go && !gen_q && (tree_par ^ g_par_q ^ monpar_q);
  assign hold_last = (state_q == S_ALARM) && (hold_q == HOLD_LAST) && !bus.GOJAM;

  parity_tree15 u_tree (
    .clk  (SIM_CLK),
    .rst  (SIM_RST),
    .en   ((state_q == S_CAPT) && !bus.GOJAM),
    .word (g_data_q),
    .par  (tree_par),
    .vld  (tree_vld)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_CAPT;
      S_CAPT:    state_d = bus.GOJAM ? S_IDLE : S_REDUCE;
      S_REDUCE:  state_d = bus.GOJAM ? S_IDLE : S_COMPARE;
      S_COMPARE: begin
        state_d = S_IDLE;
        if (fail && chk_en_q) begin
          state_d = S_ALARM;
          hold_d  = 4'd0;
        end
      end
      S_ALARM: begin
        if (bus.GOJAM)              state_d = S_IDLE;
        else if (hold_q == HOLD_LAST) state_d = S_WAITJAM;
        else                        hold_d  = hold_q + 4'd1;
      end
      S_WAITJAM: if (bus.GOJAM) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q    <= S_IDLE;
      hold_q     <= 4'd0;
      g_data_q   <= '0;
      g_par_q    <= 1'b0;
      s_addr_q   <= '0;
      gen_q      <= 1'b0;
      chk_en_q   <= 1'b0;
      monpar_q   <= 1'b0;
      pal_addr_q <= '0;
      pal_cnt_q  <= '0;
      pale_q     <= 1'b0;
      overrun_q  <= 1'b0;
      gp_out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (accept) begin
        g_data_q <= bus.G_DATA;
        g_par_q  <= bus.G_PAR;
        s_addr_q <= bus.S_ADDR;
        gen_q    <= bus.GEN_MODE;
        chk_en_q <= bus.CHK_EN;
        monpar_q <= bus.MONPAR;
      end
      if (gen_fire) gp_out_q <= tree_par;
      if (fail) begin
        // Only the first failure since reset is remembered.
        if (pal_cnt_q == '0) pal_addr_q <= s_addr_q;
        if (pal_cnt_q != '1) pal_cnt_q  <= pal_cnt_q + CNT_W'(1);
        if (chk_en_q)        pale_q     <= 1'b1;
      end
      if (((state_q == S_ALARM) || (state_q == S_WAITJAM)) && bus.GOJAM) pale_q <= 1'b0;
      if (bus.RD_STB && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

  // GP_OUT shows the fresh bit in its valid cycle and holds it afterwards.
  assign bus.GP_OUT      = gen_fire ? tree_par : gp_out_q;
  assign bus.GP_VLD      = gen_fire;
  assign bus.ERR_PULSE   = fail;
  assign bus.PALE        = pale_q;
  assign bus.PAL_ADDR    = pal_addr_q;
  assign bus.PAL_CNT     = pal_cnt_q;
  assign bus.RESTART_REQ = hold_last;
  assign bus.BUSY        = (state_q != S_IDLE);
  assign bus.OVERRUN     = overrun_q;

endmodule

// File: tb/tb_parity_alarm_sequencer.sv
// Self-checking bench for parity_alarm_sequencer: vector table, alarm corner cases, random model.
module tb_parity_alarm_sequencer;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned ALARM_HOLD = 4;

  logic SIM_CLK = 1'b0;
  logic SIM_RST;

  parity_alarm_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  parity_alarm_sequencer #(
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .ALARM_HOLD (ALARM_HOLD)
  ) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .bus     (bus)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  typedef struct packed {
    logic        gp_out;
    logic        gp_vld;
    logic        err;
    logic        pale;
    logic [11:0] addr;
    logic [7:0]  cnt;
    logic        rst_req;
    logic        busy;
    logic        overrun;
  } obs_t;

  typedef struct {
    logic [14:0] d;
    logic        gpar;
    logic [11:0] addr;
    logic        gen;
    logic        chk_en;
    logic        mon;
    logic        exp_vld;
    logic        exp_gp;
    logic        exp_err;
    int          exp_cnt;
    logic [11:0] exp_addr;
  } vec_t;

  obs_t hist [8192];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Cycle k spans posedge k..k+1; outputs of cycle k are logged at its falling edge.
  always @(posedge SIM_CLK) cyc <= cyc + 1;
  always @(negedge SIM_CLK)
    hist[13'(cyc)] = '{gp_out: bus.GP_OUT, gp_vld: bus.GP_VLD, err: bus.ERR_PULSE,
                       pale: bus.PALE, addr: bus.PAL_ADDR, cnt: bus.PAL_CNT,
                       rst_req: bus.RESTART_REQ, busy: bus.BUSY, overrun: bus.OVERRUN};

  function automatic obs_t at(input int c);
    return hist[13'(c)];
  endfunction

  function automatic int pulses(input int a, input int b, input int sel);
    int k = 0;
    for (int c = a; c <= b; c++) begin
      obs_t o;
      o = at(c);
      case (sel)
        0:       k += int'(o.gp_vld);
        1:       k += int'(o.err);
        default: k += int'(o.rst_req);
      endcase
    end
    return k;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc <= c) tick();
  endtask

  task automatic do_reset();
    SIM_RST = 1'b1;
    tick();
    tick();
    SIM_RST = 1'b0;
  endtask

  task automatic strobe(input logic [14:0] d, input logic gp, input logic [11:0] a,
                        input logic gen, input logic chk, input logic mon, output int n);
    bus.G_DATA   = d;
    bus.G_PAR    = gp;
    bus.S_ADDR   = a;
    bus.GEN_MODE = gen;
    bus.CHK_EN   = chk;
    bus.MONPAR   = mon;
    bus.RD_STB   = 1'b1;
    n = cyc;
    tick();
    bus.RD_STB = 1'b0;
  endtask

  task automatic pulse_jam(input int c);
    while (cyc < c) tick();
    bus.GOJAM = 1'b1;
    tick();
    bus.GOJAM = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [8];
    int          n, n2, r;
    int          m_cnt;
    logic [11:0] m_addr;
    logic        m_gp;

    vecs[0] = '{15'o00001, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'o0000};
    vecs[1] = '{15'o00000, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 12'o0000};
    vecs[2] = '{15'o00003, 1'b1, 12'o0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'o0000};
    vecs[3] = '{15'o00001, 1'b0, 12'o0200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'o0000};
    vecs[4] = '{15'o00003, 1'b1, 12'o4321, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 12'o4321};
    vecs[5] = '{15'o77777, 1'b1, 12'o0077, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 12'o4321};
    vecs[6] = '{15'o77777, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 12'o4321};
    vecs[7] = '{15'o00017, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 12'o4321};

    bus.G_DATA = '0; bus.G_PAR = 1'b0; bus.S_ADDR = '0; bus.RD_STB = 1'b0;
    bus.GEN_MODE = 1'b0; bus.CHK_EN = 1'b0; bus.MONPAR = 1'b0; bus.GOJAM = 1'b0;
    SIM_RST = 1'b1;

    do_reset();
    r = cyc;
    wait_until(r);
    check("reset_all_zero", int'(at(r)), 0);

    // Bad check with alarm enabled, GOJAM at n+10.
    strobe(15'o00003, 1'b0, 12'o1234, 1'b0, 1'b1, 1'b0, n);
    pulse_jam(n + 10);
    wait_until(n + 11);
    check("alarm_err_n3", int'(at(n + 3).err), 1);
    check("alarm_pale_n3", int'(at(n + 3).pale), 0);
    check("alarm_pale_n4", int'(at(n + 4).pale), 1);
    check("alarm_addr", int'(at(n + 4).addr), 12'o1234);
    check("alarm_cnt", int'(at(n + 4).cnt), 1);
    check("alarm_restart_n7", int'(at(n + 7).rst_req), 1);
    check("alarm_restart_once", pulses(n, n + 10, 2), 1);
    check("alarm_pale_n10", int'(at(n + 10).pale), 1);
    check("alarm_busy_n10", int'(at(n + 10).busy), 1);
    check("alarm_pale_n11", int'(at(n + 11).pale), 0);
    check("alarm_busy_n11", int'(at(n + 11).busy), 0);
    check("alarm_cnt_after_jam", int'(at(n + 11).cnt), 1);

    // GOJAM during ALARM hold: no restart request.
    strobe(15'o00003, 1'b0, 12'o0042, 1'b0, 1'b1, 1'b0, n);
    pulse_jam(n + 5);
    wait_until(n + 9);
    check("early_jam_no_restart", pulses(n, n + 9, 2), 0);
    check("early_jam_pale_n5", int'(at(n + 5).pale), 1);
    check("early_jam_pale_n6", int'(at(n + 6).pale), 0);
    check("early_jam_busy_n6", int'(at(n + 6).busy), 0);
    check("early_jam_cnt", int'(at(n + 6).cnt), 2);
    check("early_jam_addr_kept", int'(at(n + 6).addr), 12'o1234);

    // SIM_RST mid-ALARM.
    strobe(15'o00003, 1'b0, 12'o0042, 1'b0, 1'b1, 1'b0, n);
    while (cyc < n + 5) tick();
    SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0;
    wait_until(n + 6);
    check("midrst_pale_before", int'(at(n + 5).pale), 1);
    check("midrst_all_zero", int'(at(n + 6)), 0);

    // RD_STB together with GOJAM in IDLE.
    bus.GEN_MODE = 1'b1; bus.RD_STB = 1'b1; bus.GOJAM = 1'b1;
    n = cyc;
    tick();
    bus.RD_STB = 1'b0; bus.GOJAM = 1'b0;
    wait_until(n + 4);
    check("coinc_busy", int'(at(n + 1).busy), 0);
    check("coinc_no_vld", pulses(n, n + 4, 0), 0);
    check("coinc_no_overrun", int'(at(n + 4).overrun), 0);

    // Back-to-back words at the 4-cycle rate.
    strobe(15'o00001, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, n);
    tick(); tick(); tick();
    strobe(15'o00000, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, n2);
    wait_until(n2 + 4);
    check("tput_vld1", int'(at(n + 3).gp_vld), 1);
    check("tput_gp1", int'(at(n + 3).gp_out), 0);
    check("tput_vld2", int'(at(n2 + 3).gp_vld), 1);
    check("tput_gp2", int'(at(n2 + 3).gp_out), 1);
    check("tput_no_overrun", int'(at(n2 + 4).overrun), 0);

    // GOJAM during CAPT aborts a would-be failure.
    strobe(15'o00003, 1'b0, 12'o0011, 1'b0, 1'b1, 1'b0, n);
    pulse_jam(n + 1);
    wait_until(n + 6);
    check("capt_jam_busy_n1", int'(at(n + 1).busy), 1);
    check("capt_jam_busy_n2", int'(at(n + 2).busy), 0);
    check("capt_jam_no_err", pulses(n, n + 6, 1), 0);
    check("capt_jam_no_vld", pulses(n, n + 6, 0), 0);
    check("capt_jam_pale", int'(at(n + 6).pale), 0);
    check("capt_jam_cnt", int'(at(n + 6).cnt), 0);

    // Strobe while busy is dropped and sets OVERRUN.
    strobe(15'o00001, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, n);
    tick();
    strobe(15'o00000, 1'b0, 12'o0000, 1'b1, 1'b0, 1'b0, n2);
    wait_until(n + 8);
    check("ovr_before", int'(at(n + 2).overrun), 0);
    check("ovr_set", int'(at(n + 3).overrun), 1);
    check("ovr_one_vld", pulses(n, n + 8, 0), 1);
    check("ovr_first_word_gp", int'(at(n + 3).gp_out), 0);
    check("ovr_sticky", int'(at(n + 8).overrun), 1);

    // Vector table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].d, vecs[i].gpar, vecs[i].addr, vecs[i].gen, vecs[i].chk_en, vecs[i].mon, n);
      wait_until(n + 4);
      check($sformatf("vec%0d_busy_n1", i), int'(at(n + 1).busy), 1);
      check($sformatf("vec%0d_vld", i), int'(at(n + 3).gp_vld), int'(vecs[i].exp_vld));
      check($sformatf("vec%0d_gp", i), int'(at(n + 3).gp_out), int'(vecs[i].exp_gp));
      check($sformatf("vec%0d_gp_hold", i), int'(at(n + 4).gp_out), int'(vecs[i].exp_gp));
      check($sformatf("vec%0d_err", i), int'(at(n + 3).err), int'(vecs[i].exp_err));
      check($sformatf("vec%0d_cnt", i), int'(at(n + 4).cnt), vecs[i].exp_cnt);
      check($sformatf("vec%0d_addr", i), int'(at(n + 4).addr), int'(vecs[i].exp_addr));
      check($sformatf("vec%0d_pale", i), int'(at(n + 4).pale), 0);
      check($sformatf("vec%0d_busy_n4", i), int'(at(n + 4).busy), 0);
    end

    // Random words against a word-level model.
    do_reset();
    m_cnt = 0; m_addr = '0; m_gp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic [14:0] d;
      logic [11:0] a;
      logic        gen, mon, gp, exp_p, exp_fail;
      d     = 15'($urandom);
      a     = 12'($urandom);
      gen   = 1'($urandom);
      mon   = ($urandom_range(0, 3) == 0);
      exp_p = (($countones(d) % 2) == 0);
      gp    = mon ? exp_p : 1'($urandom);
      exp_fail = !gen && (mon || ((($countones(d) + int'(gp)) % 2) == 0));
      if (gen) m_gp = exp_p;
      if (exp_fail) begin
        if (m_cnt == 0) m_addr = a;
        if (m_cnt < 255) m_cnt++;
      end
      strobe(d, gp, a, gen, 1'b0, mon, n);
      wait_until(n + 4);
      check($sformatf("rnd%0d_vld", i), int'(at(n + 3).gp_vld), int'(gen));
      check($sformatf("rnd%0d_gp", i), int'(at(n + 3).gp_out), int'(m_gp));
      check($sformatf("rnd%0d_err", i), int'(at(n + 3).err), int'(exp_fail));
      check($sformatf("rnd%0d_cnt", i), int'(at(n + 4).cnt), m_cnt);
      check($sformatf("rnd%0d_addr", i), int'(at(n + 4).addr), int'(m_addr));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      strobe(15'o00003, 1'b1, (i == 0) ? 12'o0555 : 12'($urandom), 1'b0, 1'b0, 1'b1, n);
      tick(); tick(); tick();
    end
    wait_until(n + 4);
    check("sat_cnt_255", int'(at(n + 4).cnt), 255);
    check("sat_addr_first", int'(at(n + 4).addr), 12'o0555);
    check("sat_no_overrun", int'(at(n + 4).overrun), 0);
    strobe(15'o00003, 1'b1, 12'o0001, 1'b0, 1'b0, 1'b1, n);
    wait_until(n + 4);
    check("sat_err_still", int'(at(n + 3).err), 1);
    check("sat_no_wrap", int'(at(n + 4).cnt), 255);
    check("sat_pale", int'(at(n + 4).pale), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_alarm_sequencer.md
Name: parity_alarm_sequencer

Overview:
Downstream consumer of the parity/S-register stage. It takes the memory word on the G bus together with the S-register address, and either checks odd parity or generates the parity bit for a write-back. On a failure it runs the parity-alarm sequence: assert PALE, capture the failing address, count the event, request a restart, then wait for GOJAM to clear the alarm. It is a behavioural, clocked replacement for the discrete alarm latch and timing gates.

Parameters:
ADDR_W, 12, width of the captured S address (S01..S12)
CNT_W, 8, width of the saturating error counter
ALARM_HOLD, 4, cycles PALE is held before RESTART_REQ pulses (legal range 1..15)

Ports:
SIM_CLK  in  1  single system clock, rising-edge.
SIM_RST  in  1  synchronous, active-high reset.
G_DATA  in  15  G01..G15 memory word.
G_PAR  in  1  stored parity bit read from memory.
S_ADDR  in  ADDR_W  S-register address of the current word.
RD_STB  in  1  one-cycle pulse: G_DATA/G_PAR/S_ADDR valid (T07PHS4 equivalent).
GEN_MODE  in  1  sampled with RD_STB: 1 = generate parity, 0 = check.
CHK_EN  in  1  sampled with RD_STB: 0 suppresses the alarm (check still runs; ERR_PULSE still fires).
MONPAR  in  1  sampled with RD_STB: forces a bad-parity result (monitor test).
GOJAM  in  1  restart acknowledge; clears the alarm.
GP_OUT  out  1  generated parity bit (odd parity over G_DATA).
GP_VLD  out  1  one-cycle pulse: GP_OUT valid.
ERR_PULSE  out  1  one-cycle pulse per failed check.
PALE  out  1  parity alarm, level.
PAL_ADDR  out  ADDR_W  address of the first failure since reset.
PAL_CNT  out  CNT_W  saturating failure count.
RESTART_REQ  out  1  one-cycle restart request.
BUSY  out  1  high whenever state is not IDLE.
OVERRUN  out  1  sticky: RD_STB arrived while BUSY.

Behaviour:
- Reset (synchronous): every output is 0; state = IDLE; internal registers cleared.
- States: IDLE, CAPT, REDUCE, COMPARE, ALARM, WAITJAM.
- IDLE:
  - On RD_STB, latch G_DATA, G_PAR, S_ADDR, GEN_MODE, CHK_EN, MONPAR; go to CAPT.
- CAPT:
  - Stage 1: two partial XORs (bits 1–8, bits 9–15) registered; go to REDUCE.
- REDUCE:
  - Stage 2: p = ~(xor of partials) gives the odd-parity generate bit; chk = p ^ G_PAR ^ MONPAR gives the error bit; go to COMPARE.
- COMPARE (cycle n+3 when RD_STB is in cycle n):
  - GEN_MODE = 1: GP_OUT <= p, GP_VLD = 1 for one cycle; next state IDLE.
  - GEN_MODE = 0, chk = 0: next state IDLE, no outputs change.
  - GEN_MODE = 0, chk = 1:
    - ERR_PULSE = 1 for one cycle.
    - PAL_CNT increments and saturates at 2^CNT_W−1.
    - PAL_ADDR is loaded only if PAL_CNT was 0 before this event.
    - If CHK_EN = 1: PALE <= 1, go to ALARM. Otherwise go to IDLE.
- ALARM:
  - Hold counter runs ALARM_HOLD cycles.
  - On the last hold cycle RESTART_REQ = 1 for exactly one cycle; go to WAITJAM.
- WAITJAM:
  - PALE stays high until GOJAM; on GOJAM, PALE <= 0 and go to IDLE.
- GOJAM in ALARM: ends the sequence early; PALE cleared, no RESTART_REQ, go to IDLE.
- GOJAM in CAPT/REDUCE/COMPARE: abort the in-flight operation, no outputs from it, go to IDLE.
- RD_STB while BUSY: the strobe is dropped and OVERRUN <= 1 (sticky until SIM_RST).
- RD_STB coincident with GOJAM in IDLE: GOJAM wins; the strobe is ignored and OVERRUN is not set.
- PAL_ADDR and PAL_CNT survive GOJAM and clear only on SIM_RST.
- GP_OUT holds its last value between GP_VLD pulses.
- SIM_RST mid-sequence: immediate return to reset values in the next cycle.
- Throughput: one word per 4 cycles (RD_STB in cycle n accepted again in cycle n+4).

Decomposition:
- Shared package (agc_parity_pkg):
  - state enum for the six states;
  - constants WORD_W = 15, ADDR_W_DEF = 12;
  - function odd_parity(word).
- One sub-module, parity_tree15: a two-stage registered XOR reduction. Inputs: 15-bit word and enable. Outputs: parity bit and valid. Latency 2.

Test Plan:
- Generate mode, G_DATA = 15'o00001 -> GP_VLD at n+3 with GP_OUT = 0; G_DATA = 15'o00000 -> GP_OUT = 1.
- Good check, G_DATA = 15'o00003, G_PAR = 1, CHK_EN = 1 -> no ERR_PULSE, PALE stays 0, BUSY low at n+4.
- Bad check, G_DATA = 15'o00003, G_PAR = 0, S_ADDR = 12'o1234, CHK_EN = 1, ALARM_HOLD = 4:
  - ERR_PULSE at n+3; PALE = 1 from n+4; RESTART_REQ at n+7; PAL_ADDR = 12'o1234; PAL_CNT = 1.
  - GOJAM at n+10 -> PALE = 0 at n+11.
- MONPAR = 1 on good parity with CHK_EN = 0 -> ERR_PULSE, PAL_CNT increments, PALE stays 0. A second failure at address 12'o0077 -> PAL_ADDR remains the first address.
- RD_STB at n and n+2 -> second strobe dropped, OVERRUN = 1. Separately, GOJAM at n+1 during CAPT -> no ERR_PULSE or GP_VLD; IDLE at n+2.
- 255 forced failures with CNT_W = 8, then one more -> PAL_CNT = 255 and does not wrap. SIM_RST mid-ALARM -> all outputs 0 on the next cycle.
